// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection and operand-forwarding control.
// Produces the ALU forwarding selects, a load-use stall of LOAD_LAT cycles,
// and a one-entry scoreboard that stalls decode while a multi-cycle (MDU)
// result is still pending.
// Optional feature: define WB_BYPASS_EN to add the wb2_rd/wb2_wb ports and
// the lowest-priority forward select 2'b11 from the stage after writeback.
module hazard_unit #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] id_rs1,
   input  logic [AW-1:0] id_rs2,
   input  logic          id_use_rs1,
   input  logic          id_use_rs2,
   input  logic [AW-1:0] ex_rs1,
   input  logic [AW-1:0] ex_rs2,
   input  logic [AW-1:0] ex_rd,
   input  logic          ex_wb,
   input  logic          ex_mem_read,
   input  logic [AW-1:0] mem_rd,
   input  logic          mem_wb,
   input  logic [AW-1:0] wb_rd,
   input  logic          wb_wb,
   input  logic          mdu_start,
   input  logic          mdu_done,
`ifdef WB_BYPASS_EN
   input  logic [AW-1:0] wb2_rd,
   input  logic          wb2_wb,
`endif
   output logic [1:0]    forwardA,
   output logic [1:0]    forwardB,
   output logic          stall_if,
   output logic          stall_id,
   output logic          flush_ex,
   output logic          mdu_busy
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MDU_WAIT = 2'd2
   } state_t;

   // The cycle that detects the load hazard is itself the first stall cycle,
   // so the counter only covers the remaining LOAD_LAT-1 cycles.
   localparam logic [3:0] CNT_LOAD = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            busy;
   logic [AW-1:0]   pend_rd;
   logic            ld_haz;
   logic            mdu_dep;
   logic            stall;
   logic [1:0]      fwd_a, fwd_b;

   // Forward select priority: EX/MEM, then MEM/WB, then (optionally) WB+1.
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] rs,
      input logic          m_wb,
      input logic [AW-1:0] m_rd,
      input logic          w_wb,
      input logic [AW-1:0] w_rd,
      input logic          w2_wb,
      input logic [AW-1:0] w2_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_wb && (m_rd != '0) && (m_rd == rs))
         sel = 2'b10;
      else if (w_wb && (w_rd != '0) && (w_rd == rs))
         sel = 2'b01;
      else if (w2_wb && (w2_rd != '0) && (w2_rd == rs))
         sel = 2'b11;
      return sel;
   endfunction

   // Zero-latency operand forwarding selects.
   always_comb begin
`ifdef WB_BYPASS_EN
      fwd_a = fwd_sel(ex_rs1, mem_wb, mem_rd, wb_wb, wb_rd, wb2_wb, wb2_rd);
      fwd_b = fwd_sel(ex_rs2, mem_wb, mem_rd, wb_wb, wb_rd, wb2_wb, wb2_rd);
`else
      fwd_a = fwd_sel(ex_rs1, mem_wb, mem_rd, wb_wb, wb_rd, 1'b0, '0);
      fwd_b = fwd_sel(ex_rs2, mem_wb, mem_rd, wb_wb, wb_rd, 1'b0, '0);
`endif
   end

   // Hazard conditions seen by the decode-stage instruction.
   always_comb begin
      ld_haz  = ex_mem_read && ex_wb && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));
      mdu_dep = busy && (pend_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == pend_rd)) ||
                 (id_use_rs2 && (id_rs2 == pend_rd)));
   end

   // FSM state and load-stall counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FSM next state; a load hazard wins over a pending MDU dependency.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (ld_haz) begin
               if (LOAD_LAT > 1) begin
                  state_nxt = LD_STALL;
                  cnt_nxt   = CNT_LOAD;
               end
            end else if (mdu_dep && !mdu_done) begin
               state_nxt = MDU_WAIT;
            end
         end
         LD_STALL: begin
            if (cnt == 4'd0)
               state_nxt = RUN;
            else
               cnt_nxt = cnt - 4'd1;
         end
         MDU_WAIT: begin
            if (mdu_done)
               state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // FSM outputs; an MDU stall drops in the same cycle mdu_done arrives.
   always_comb begin
      stall = ((state == RUN) && ld_haz) ||
              (state == LD_STALL) ||
              (mdu_dep && !mdu_done);
   end

   // One-entry scoreboard; a start while busy is dropped unless the
   // pending result retires in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy    <= 1'b0;
         pend_rd <= '0;
      end else if (mdu_start && (!busy || mdu_done)) begin
         busy    <= 1'b1;
         pend_rd <= ex_rd;
      end else if (mdu_done) begin
         busy    <= 1'b0;
      end
   end

   // Outputs are forced quiet while reset is asserted.
   assign forwardA = rstn ? fwd_a : 2'b00;
   assign forwardB = rstn ? fwd_b : 2'b00;
   assign stall_if = rstn & stall;
   assign stall_id = rstn & stall;
   assign flush_ex = rstn & stall;
   assign mdu_busy = rstn & busy;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with LOAD_LAT=3.
module tb_hazard_unit;

   localparam int AW = 5;
   localparam int LL = 3;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic          id_use_rs1, id_use_rs2, ex_wb, ex_mem_read, mem_wb, wb_wb;
   logic          mdu_start, mdu_done;
   logic [AW-1:0] wb2_rd;
   logic          wb2_wb;
   logic [1:0]    forwardA, forwardB;
   logic          stall_if, stall_id, flush_ex, mdu_busy;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit            m_busy    = 1'b0;
   logic [AW-1:0] m_pend    = '0;
   int            m_ld_left = 0;
   bit            m_wait    = 1'b0;

   logic [7:0] pat;

   hazard_unit #(.AW(AW), .LOAD_LAT(LL)) dut (
      .clk(clk), .rstn(rstn),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_wb(mem_wb),
      .wb_rd(wb_rd), .wb_wb(wb_wb),
      .mdu_start(mdu_start), .mdu_done(mdu_done),
`ifdef WB_BYPASS_EN
      .wb2_rd(wb2_rd), .wb2_wb(wb2_wb),
`endif
      .forwardA(forwardA), .forwardB(forwardB),
      .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
      .mdu_busy(mdu_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
      if (mem_wb && mem_rd != 0 && mem_rd == rs) return 2'b10;
      if (wb_wb && wb_rd != 0 && wb_rd == rs) return 2'b01;
`ifdef WB_BYPASS_EN
      if (wb2_wb && wb2_rd != 0 && wb2_rd == rs) return 2'b11;
`endif
      return 2'b00;
   endfunction

   function automatic bit m_ld();
      return ex_mem_read && ex_wb && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
   endfunction

   function automatic bit m_dep();
      return m_busy && m_pend != 0 &&
             ((id_use_rs1 && id_rs1 == m_pend) || (id_use_rs2 && id_rs2 == m_pend));
   endfunction

   function automatic bit m_stall();
      if (m_ld_left > 0) return 1'b1;
      if (!m_wait && m_ld()) return 1'b1;
      return m_dep() && !mdu_done;
   endfunction

   // model update on each clock edge
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy <= 1'b0; m_pend <= '0; m_ld_left <= 0; m_wait <= 1'b0;
      end else begin
         if (m_ld_left > 0)           m_ld_left <= m_ld_left - 1;
         else if (m_wait)             begin if (mdu_done) m_wait <= 1'b0; end
         else if (m_ld())             m_ld_left <= LL - 1;
         else if (m_dep() && !mdu_done) m_wait <= 1'b1;
         if (mdu_start && (!m_busy || mdu_done)) begin
            m_busy <= 1'b1; m_pend <= ex_rd;
         end else if (mdu_done) begin
            m_busy <= 1'b0;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (!rstn) begin
         chk("m_fwdA", {6'd0, forwardA}, 8'd0);
         chk("m_fwdB", {6'd0, forwardB}, 8'd0);
         chk("m_stall", {5'd0, stall_if, stall_id, flush_ex}, 8'd0);
         chk("m_busy", {7'd0, mdu_busy}, 8'd0);
      end else begin
         chk("m_fwdA", {6'd0, forwardA}, {6'd0, m_fwd(ex_rs1)});
         chk("m_fwdB", {6'd0, forwardB}, {6'd0, m_fwd(ex_rs2)});
         chk("m_stall", {5'd0, stall_if, stall_id, flush_ex}, {5'd0, {3{m_stall()}}});
         chk("m_busy", {7'd0, mdu_busy}, {7'd0, m_busy});
      end
   end

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_wb = 0; ex_mem_read = 0;
      mem_rd = 0; mem_wb = 0; wb_rd = 0; wb_wb = 0;
      mdu_start = 0; mdu_done = 0; wb2_rd = 0; wb2_wb = 0;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic set_load_hazard();
      ex_mem_read = 1; ex_wb = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
   endtask

   // forwarding vectors: mem_wb, mem_rd, wb_wb, wb_rd, ex_rs1, ex_rs2, expA, expB
   typedef struct { logic mw; logic [4:0] mr; logic ww; logic [4:0] wr;
                    logic [4:0] r1; logic [4:0] r2; logic [1:0] ea; logic [1:0] eb; } fv_t;
   fv_t fv [6];

   initial begin
      fv[0] = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10};
      fv[1] = '{1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 2'b01};
      fv[2] = '{1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6, 2'b01, 2'b00};
      fv[3] = '{1'b1, 5'd6, 1'b1, 5'd5, 5'd5, 5'd6, 2'b01, 2'b10};
      fv[4] = '{1'b1, 5'd7, 1'b0, 5'd5, 5'd5, 5'd6, 2'b00, 2'b00};
      fv[5] = '{1'b1, 5'd3, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};

      idle();
      // reset: outputs quiet even with a forwarding match present
      mem_wb = 1; mem_rd = 5; ex_rs1 = 5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fwdA", {6'd0, forwardA}, 8'd0);
      chk("rst_stall", {7'd0, stall_if}, 8'd0);
      chk("rst_busy", {7'd0, mdu_busy}, 8'd0);
      @(posedge clk); #1;
      rstn = 1; idle();

      // forwarding table
      foreach (fv[i]) begin
         mem_wb = fv[i].mw; mem_rd = fv[i].mr; wb_wb = fv[i].ww; wb_rd = fv[i].wr;
         ex_rs1 = fv[i].r1; ex_rs2 = fv[i].r2;
         #1;
         chk("fwdA_vec", {6'd0, forwardA}, {6'd0, fv[i].ea});
         chk("fwdB_vec", {6'd0, forwardB}, {6'd0, fv[i].eb});
         nxt();
      end
      idle();

      // writeback+1 bypass
      wb2_wb = 1; wb2_rd = 4; ex_rs2 = 4;
      #1;
`ifdef WB_BYPASS_EN
      chk("fwd_wb2", {6'd0, forwardB}, 8'd3);
`else
      chk("fwd_wb2", {6'd0, forwardB}, 8'd0);
`endif
      nxt(); idle();

      // load-use boundaries that must not stall
      set_load_hazard(); ex_rd = 0; id_rs2 = 0;
      @(negedge clk); chk("ld_rd0", {7'd0, stall_if}, 8'd0);
      nxt(); set_load_hazard(); ex_wb = 0;
      @(negedge clk); chk("ld_nowb", {7'd0, stall_if}, 8'd0);
      nxt(); set_load_hazard(); id_use_rs2 = 0;
      @(negedge clk); chk("ld_nouse", {7'd0, stall_if}, 8'd0);
      nxt(); idle();

      // load-use stall: exactly LL cycles; the load leaves EX after one cycle
      set_load_hazard();
      pat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); pat[i] = stall_if;
         nxt();
         if (i == 0) begin ex_mem_read = 0; ex_wb = 0; ex_rd = 0; end
      end
      chk("ld_pattern", pat, 8'b0000_0111);
      chk("ld_len", 8'($countones(pat)), 8'd3);
      idle();

      // MDU dependency: 4 stall cycles, release in the done cycle
      mdu_start = 1; ex_rd = 9;
      @(negedge clk); chk("mdu_issue", {7'd0, stall_if}, 8'd0);
      nxt();
      mdu_start = 0; ex_rd = 0; id_rs1 = 9; id_use_rs1 = 1;
      pat = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); pat[i] = stall_if;
         nxt();
      end
      chk("mdu_pattern", pat, 8'b0000_1111);
      mdu_done = 1;
      @(negedge clk);
      chk("mdu_release", {7'd0, stall_if}, 8'd0);
      chk("mdu_busy_hold", {7'd0, mdu_busy}, 8'd1);
      nxt(); mdu_done = 0;
      @(negedge clk); chk("mdu_busy_fall", {7'd0, mdu_busy}, 8'd0);
      nxt(); idle();

      // simultaneous done+start captures new rd
      mdu_start = 1; ex_rd = 9;
      nxt(); mdu_done = 1; ex_rd = 3;
      @(negedge clk); chk("swap_busy", {7'd0, mdu_busy}, 8'd1);
      nxt(); idle(); id_rs1 = 9; id_use_rs1 = 1;
      @(negedge clk);
      chk("swap_old_rd", {7'd0, stall_if}, 8'd0);
      chk("swap_busy2", {7'd0, mdu_busy}, 8'd1);
      nxt(); id_rs1 = 3;
      @(negedge clk); chk("swap_new_rd", {7'd0, stall_if}, 8'd1);
      nxt(); mdu_done = 1;
      @(negedge clk); chk("swap_release", {7'd0, stall_if}, 8'd0);
      nxt(); idle();

      // start while busy is ignored
      mdu_start = 1; ex_rd = 10;
      nxt(); ex_rd = 11;
      nxt(); idle(); id_rs2 = 11; id_use_rs2 = 1;
      @(negedge clk); chk("ign_second", {7'd0, stall_if}, 8'd0);
      nxt(); id_rs2 = 10;
      @(negedge clk); chk("keep_first", {7'd0, stall_if}, 8'd1);
      nxt(); mdu_done = 1;
      nxt(); idle();

      // done while idle is ignored
      mdu_done = 1;
      nxt(); mdu_done = 0;
      @(negedge clk); chk("done_idle", {7'd0, mdu_busy}, 8'd0);
      nxt();

      // reset in the middle of a load stall
      set_load_hazard(); mem_wb = 1; mem_rd = 5; ex_rs1 = 5;
      @(negedge clk); chk("pre_rst_stall", {7'd0, stall_if}, 8'd1);
      nxt(); ex_mem_read = 0; ex_wb = 0; ex_rd = 0;
      #1;
      chk("in_ld_stall", {7'd0, stall_if}, 8'd1);
      rstn = 0;
      #1;
      chk("arst_stall", {5'd0, stall_if, stall_id, flush_ex}, 8'd0);
      chk("arst_fwdA", {6'd0, forwardA}, 8'd0);
      chk("arst_busy", {7'd0, mdu_busy}, 8'd0);
      nxt();
      rstn = 1; idle();
      @(negedge clk); chk("post_rst_run", {7'd0, stall_if}, 8'd0);
      nxt();
      set_load_hazard();
      @(negedge clk); chk("post_rst_ld", {7'd0, stall_if}, 8'd1);
      nxt(); idle();
      repeat (4) nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
